// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the blank pattern and the hex-to-glyph table (active-high, bit 0 = segment a).
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Element [n] is the glyph for nibble n; 0xA..0xF render as A,b,C,d,E,F.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment glyph decoder (active-high segments).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  assign o_glyph = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow-buffered loads that are
// applied only at frame boundaries, and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic                    r_frame_done;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_sel;

  logic                    w_div_last;
  logic                    w_boundary;
  logic [3:0]              w_nibble;
  logic                    w_dp;
  logic [6:0]              w_glyph;
  logic                    w_zero_above;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic                    w_blank;
  logic [7:0]              w_seg_hi;
  logic [NUM_DIGITS-1:0]   w_sel_hi;

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Scan position decode, leading-zero mask and active-high output pattern.
  always_comb begin
    w_div_last   = (r_div == DIV_LAST);
    w_boundary   = enable & w_div_last & (r_idx == IDX_LAST);
    w_nibble     = r_disp_data[{r_idx, 2'b00} +: 4];
    w_dp         = r_disp_dp[r_idx];
    // Walk from the top digit down; a digit blanks while every digit at or above it is zero.
    w_zero_above = 1'b1;
    w_blank_mask = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above    = w_zero_above & (r_disp_data[4*i +: 4] == 4'h0);
      w_blank_mask[i] = w_zero_above & (i != 0);
    end
    w_blank          = blank_lz & w_blank_mask[r_idx];
    w_seg_hi         = 8'h00;
    w_seg_hi[SEG_DP] = w_dp;
    w_seg_hi[SEG_G:SEG_A] = w_blank ? SEG_BLANK : w_glyph;
    w_sel_hi         = NUM_DIGITS'(1'b1) << r_idx;
  end

  // Digit divider and scan index; both freeze while enable is low.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (enable) begin
      if (w_div_last) begin
        r_div <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end else begin
      r_div <= r_div;
      r_idx <= r_idx;
    end
  end

  // Shadow capture and frame-boundary transfer; a coincident load bypasses the shadow.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pending     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else if (w_boundary) begin
      r_frame_done <= 1'b1;
      r_pending    <= 1'b0;
      if (load) begin
        r_disp_data <= data_in;
        r_disp_dp   <= dp_in;
      end else if (r_pending) begin
        r_disp_data <= r_shadow_data;
        r_disp_dp   <= r_shadow_dp;
      end else begin
        r_disp_data <= r_disp_data;
        r_disp_dp   <= r_disp_dp;
      end
    end else begin
      r_frame_done <= 1'b0;
      if (load) begin
        r_shadow_data <= data_in;
        r_shadow_dp   <= dp_in;
        r_pending     <= 1'b1;
      end else begin
        r_shadow_data <= r_shadow_data;
        r_shadow_dp   <= r_shadow_dp;
        r_pending     <= r_pending;
      end
    end
  end

  // Output registers; polarity is applied only here.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_seg <= SEG_OFF;
      r_sel <= SEL_OFF;
    end else if (enable) begin
      r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
      r_sel <= (SEL_ACTIVE_LOW != 0) ? ~w_sel_hi : w_sel_hi;
    end else begin
      r_seg <= SEG_OFF;
      r_sel <= SEL_OFF;
    end
  end

  assign o_seg      = r_seg;
  assign o_sel      = r_sel;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter CLK_DIV, default 100000: clk_in cycles each digit is driven, legal range >= 1.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means o_seg bits are driven 0 to light a segment.
REQ-004 SHALL have parameter SEL_ACTIVE_LOW, default 1: 1 means o_sel bits are driven 0 to select a digit.
REQ-005 SHALL use a single clock clk_in and a synchronous, active-low reset named reset.
REQ-006 SHALL have these ports:
  clk_in  in  1  clock
  reset  in  1  synchronous active-low reset
  enable  in  1  scan enable
  load  in  1  capture data_in/dp_in request, one cycle
  data_in  in  4*NUM_DIGITS  hex nibbles, digit i = data_in[4i+3:4i]
  dp_in  in  NUM_DIGITS  decimal point per digit
  blank_lz  in  1  leading-zero blanking mode
  o_seg  out  8  [7]=dp, [6:0]=g..a
  o_sel  out  NUM_DIGITS  one-hot (in active polarity) digit select
  frame_done  out  1  one-cycle pulse at frame boundary
  pending  out  1  captured value awaiting display

Function
REQ-007 SHALL decode nibbles 0x0..0xF to standard hex glyphs (A,b,C,d,E,F for 0xA..0xF).
REQ-008 SHALL hold digit index idx for exactly CLK_DIV enabled cycles, then advance idx 0,1,..,NUM_DIGITS-1, wrapping to 0.
REQ-009 SHALL register o_seg and o_sel; they reflect the current idx one cycle after idx changes.
REQ-010 SHALL assert exactly one o_sel bit when enable=1, namely bit idx.
REQ-011 SHALL, when enable=0, hold the divider and idx, and drive o_seg and o_sel fully inactive from the next cycle.
REQ-012 SHALL, on load=1, copy data_in/dp_in into a shadow register and set pending=1; a later load before transfer overwrites it (latest wins).
REQ-013 SHALL transfer the shadow register to the display register only at the frame boundary, i.e. when idx wraps from NUM_DIGITS-1 to 0, and clear pending then.
REQ-014 SHALL, when load coincides with the frame boundary, place the same-cycle data_in/dp_in directly into the display register and leave pending=0.
REQ-015 SHALL pulse frame_done for one cycle on every frame boundary, whether or not a transfer occurred.
REQ-016 SHALL, when blank_lz=1, blank the segments [6:0] of each zero digit above the highest non-zero digit; digit 0 is never blanked.
REQ-017 SHALL still light the dp on a blanked digit if its dp bit is set.
REQ-018 SHALL, for CLK_DIV=1, advance idx every enabled cycle.
REQ-019 SHALL, for NUM_DIGITS=1, pulse frame_done every CLK_DIV enabled cycles, with o_sel constantly active.
REQ-020 SHALL apply the polarity parameters only at the output registers.

Reset
REQ-021 SHALL, while reset=0 at a clk_in edge, clear the divider, idx, display and shadow registers, and set pending=0 and frame_done=0.
REQ-022 SHALL drive o_seg and o_sel fully inactive after reset: all ones when the corresponding ACTIVE_LOW parameter is 1, all zeros otherwise.
REQ-023 SHALL, on reset mid-frame, discard any pending load; scanning restarts at idx 0 on the first cycle after release.

Structure
REQ-024 SHALL place the hex-to-segment table, the segment bit-position constants and the blank-pattern constant in shared package seg7_pkg.
REQ-025 SHALL implement the nibble decode as combinational sub-module seg7_decode (4-bit in, 7-bit active-high out).
REQ-026 SHALL size the divider and idx counters with $clog2 of CLK_DIV and NUM_DIGITS, at least 1 bit each.

Verification (NUM_DIGITS=4, CLK_DIV=3, both active-low)
REQ-027 Reset: hold reset=0 for 2 cycles -> o_seg=8'hFF, o_sel=4'hF, pending=0, frame_done=0.
REQ-028 Scan: enable=1, load data_in=16'h12AF -> pending=1 until the boundary; the next frame shows o_sel 1110 with F, 1101 with A, 1011 with 2, 0111 with 1, each for 3 cycles; frame_done pulses every 12 cycles.
REQ-029 Coincident load: load 16'h0005 exactly on the boundary cycle -> the display updates in that frame, pending stays 0.
REQ-030 Leading-zero blanking: blank_lz=1, data_in=16'h0050, dp_in=4'b1000 -> digits 3 and 2 have segments off, digit 3 shows dp only, digit 1 shows "5", digit 0 shows "0".
REQ-031 Enable drop: enable=0 mid-digit for 5 cycles -> outputs inactive; on re-enable the same idx resumes with the remaining divider count.
REQ-032 Mid-frame reset: load 16'h9999 then reset before the boundary -> after release pending=0 and the display shows 0000.
